// File: rtl/f2i_pkg.sv
// Shared widths and FSM state encoding for the mini-float to integer converter.
package f2i_pkg;

  localparam int FLT_W = 7;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int INT_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/float_unpack.sv
// Combinational field decode: splits exp/man, restores the hidden bit and
// derives how many left shifts the converter still has to perform.
module float_unpack
  import f2i_pkg::*;
(
  input  logic [FLT_W-1:0] flt,
  output logic [INT_W-1:0] mant_ext,
  output logic [EXP_W-1:0] shift_cnt
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             hidden;

  assign exp_f  = flt[FLT_W-1:MAN_W];
  assign man_f  = flt[MAN_W-1:0];
  // exp==0 is the denormal-like case: value is the mantissa alone
  assign hidden = |exp_f;

  assign mant_ext  = INT_W'({hidden, man_f});
  assign shift_cnt = hidden ? (exp_f - EXP_W'(1)) : '0;

endmodule

// File: rtl/float2int_seq.sv
// Sequential mini-float to unsigned integer converter: loads the unpacked
// mantissa, shifts it left STEP bits per cycle, then holds the result.
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// SHIFT | shifting acc toward its final position, input stalled
// HOLD  | result on out_int, out_valid high until consumed
module float2int_seq
  import f2i_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLT_W-1:0] in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic [15:0]      conv_count
);

  localparam logic [EXP_W-1:0] STEP_V = EXP_W'(STEP);

  state_t           state;
  logic [INT_W-1:0] acc;
  logic [EXP_W-1:0] cnt;
  logic [INT_W-1:0] unp_acc;
  logic [EXP_W-1:0] unp_cnt;
  logic [EXP_W-1:0] sh;
  logic             load;

  float_unpack u_unpack (
    .flt      (in_float),
    .mant_ext (unp_acc),
    .shift_cnt(unp_cnt)
  );

  // HOLD accepts a new input in the same cycle its result is consumed
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign load     = in_valid && in_ready;
  assign sh       = (cnt > STEP_V) ? STEP_V : cnt;
  assign out_int  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      conv_count <= '0;
    end else begin
      if (out_valid && out_ready && (conv_count != 16'hFFFF))
        conv_count <= conv_count + 16'd1;

      if (load) begin
        acc <= unp_acc;
        cnt <= unp_cnt;
        if (unp_cnt == '0) begin
          state     <= HOLD;
          out_valid <= 1'b1;
        end else begin
          state     <= SHIFT;
          out_valid <= 1'b0;
        end
      end else begin
        case (state)
          SHIFT: begin
            acc <= acc << sh;
            cnt <= cnt - sh;
            if (cnt == sh) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
          IDLE: ;
          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
